fifo_ctrl: RTL and testbench

//  Pointer/flag controller for the main FIFO: turns push/pop requests into write/read

---
 rtl/fifo_ctrl.sv | 158 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the main FIFO RAM: write/read strobes, RAM addresses,
// occupancy and status flags, sequenced by a RESET/INIT/IDLE/ACTIVE/ERROR FSM.
module fifo_ctrl #(
  parameter int unsigned PTR_SIZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [PTR_SIZE-1:0] th_afull,
  input  logic [PTR_SIZE-1:0] th_aempty,
  input  logic                push,
  input  logic                pop,
  output logic                mem_write,
  output logic                mem_read,
  output logic [PTR_SIZE-1:0] wr_ptr,
  output logic [PTR_SIZE-1:0] rd_ptr,
  output logic                valid_out,
  output logic [PTR_SIZE-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                error,
  output logic [2:0]          state
);

  // One RAM slot is always sacrificed, so usable depth is one short of the slot count.
  localparam int unsigned         DEPTH_USE = (1 << PTR_SIZE) - 1;
  localparam logic [PTR_SIZE-1:0] CNT_FULL  = PTR_SIZE'(DEPTH_USE);
  localparam logic [PTR_SIZE-1:0] PTR_ONE   = PTR_SIZE'(1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t              cur_state;
  state_t              nxt_state;
  logic [PTR_SIZE-1:0] th_af_q;
  logic [PTR_SIZE-1:0] th_ae_q;
  logic [PTR_SIZE-1:0] nxt_wr_ptr;
  logic [PTR_SIZE-1:0] nxt_rd_ptr;
  logic [PTR_SIZE-1:0] nxt_count;
  logic [PTR_SIZE-1:0] nxt_th_af;
  logic [PTR_SIZE-1:0] nxt_th_ae;
  logic                nxt_full;
  logic                nxt_empty;
  logic                nxt_afull;
  logic                nxt_aempty;
  logic                nxt_error;
  logic                clear;
  logic                op_en;
  logic                overflow;
  logic                underflow;

  // Strobes are combinational so the RAM sees them in the request cycle.
  assign op_en     = ((cur_state == S_IDLE) || (cur_state == S_ACTIVE)) && !reset && !init;
  assign mem_read  = op_en & pop & ~empty;
  assign mem_write = op_en & push & (~full | mem_read);
  assign overflow  = op_en & push & full & ~pop;
  assign underflow = op_en & pop & empty;
  assign state     = cur_state;

  // Next-state and next-datapath values.
  always_comb begin
    nxt_state  = cur_state;
    nxt_wr_ptr = wr_ptr;
    nxt_rd_ptr = rd_ptr;
    nxt_count  = count;
    nxt_th_af  = th_af_q;
    nxt_th_ae  = th_ae_q;
    nxt_error  = error;
    clear      = 1'b0;
    unique case (cur_state)
      S_RESET: nxt_state = S_INIT;
      S_INIT: begin
        nxt_th_af = th_afull;
        nxt_th_ae = th_aempty;
        clear     = 1'b1;
        if (!init) nxt_state = S_IDLE;
      end
      S_IDLE, S_ACTIVE: begin
        if (init) begin
          nxt_state = S_INIT;
          clear     = 1'b1;
        end else begin
          if (mem_write) nxt_wr_ptr = wr_ptr + PTR_ONE;
          if (mem_read)  nxt_rd_ptr = rd_ptr + PTR_ONE;
          if (mem_write && !mem_read)      nxt_count = count + PTR_ONE;
          else if (mem_read && !mem_write) nxt_count = count - PTR_ONE;
          // The non-offending op of an error cycle still lands; the offending one is dropped.
          if (overflow || underflow) begin
            nxt_state = S_ERROR;
            nxt_error = 1'b1;
          end else begin
            nxt_state = (nxt_count == '0) ? S_IDLE : S_ACTIVE;
          end
        end
      end
      S_ERROR: begin
        if (init) begin
          nxt_state = S_INIT;
          clear     = 1'b1;
        end
      end
      default: nxt_state = S_RESET;
    endcase
    if (clear) begin
      nxt_wr_ptr = '0;
      nxt_rd_ptr = '0;
      nxt_count  = '0;
      nxt_error  = 1'b0;
    end
    nxt_full   = (nxt_count == CNT_FULL);
    nxt_empty  = (nxt_count == '0);
    nxt_afull  = (nxt_count >= nxt_th_af);
    nxt_aempty = (nxt_count <= nxt_th_ae);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_RESET;
    else       cur_state <= nxt_state;
  end

  // Pointers, occupancy, thresholds and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      th_af_q      <= '0;
      th_ae_q      <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      error        <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      wr_ptr       <= nxt_wr_ptr;
      rd_ptr       <= nxt_rd_ptr;
      count        <= nxt_count;
      th_af_q      <= nxt_th_af;
      th_ae_q      <= nxt_th_ae;
      full         <= nxt_full;
      empty        <= nxt_empty;
      almost_full  <= nxt_afull;
      almost_empty <= nxt_aempty;
      error        <= nxt_error;
      valid_out    <= mem_read;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based occupancy model.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       init;
  logic [2:0] th_afull;
  logic [2:0] th_aempty;
  logic       push;
  logic       pop;
  logic       mem_write;
  logic       mem_read;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       valid_out;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
  logic [2:0] state;

  int          total;
  int          bad;
  logic [17:0] obs;
  logic [17:0] exp_v;
  logic [1:0]  strb;

  fifo_ctrl #(.PTR_SIZE(3)) dut (
    .clk(clk), .reset(reset), .init(init), .th_afull(th_afull), .th_aempty(th_aempty),
    .push(push), .pop(pop), .mem_write(mem_write), .mem_read(mem_read),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .valid_out(valid_out), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs  = {state, count, wr_ptr, rd_ptr, full, empty, almost_full, almost_empty, error, valid_out};
  assign strb = {mem_write, mem_read};

  // Packs an expected status word in the same field order as obs.
  function automatic logic [17:0] pk(int s, int c, int w, int r, bit f, bit e, bit af, bit ae,
                                     bit er, bit v);
    return {3'(s), 3'(c), 3'(w), 3'(r), f, e, af, ae, er, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; push = 1'b1; pop = 1'b1; th_afull = 3'd5; th_aempty = 3'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (strb !== 2'b00) begin bad++; $display("FAIL reset_strobe: got %b want 00", strb); end
      tick();
      exp_v = pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    end
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    tick();
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL reset_to_init: got %0d want 1", state); end
    tick();
    exp_v = pk(2, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; pop = 1'b0;
      #1;
      total++;
      if ({strb, wr_ptr} !== {2'b10, 3'(i)}) begin
        bad++; $display("FAIL fill_strobe: got %b/%0d want 10/%0d", strb, wr_ptr, i);
      end
      tick();
      exp_v = pk(3, i + 1, i + 1, 0, (i + 1) == 7, 0, (i + 1) >= 5, (i + 1) <= 1, 0, 0);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL fill_status: got %h want %h", obs, exp_v); end
    end
    #1;
    total++;
    if (strb !== 2'b00) begin bad++; $display("FAIL overflow_strobe: got %b want 00", strb); end
    tick();
    exp_v = pk(4, 7, 7, 0, 1, 0, 1, 0, 1, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL overflow_error: got %h want %h", obs, exp_v); end
    push = 1'b0; pop = 1'b1;
    #1;
    total++;
    if (strb !== 2'b00) begin bad++; $display("FAIL error_strobe: got %b want 00", strb); end
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL error_frozen: got %h want %h", obs, exp_v); end
    pop = 1'b0; init = 1'b1;
    tick();
    exp_v = pk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL error_init: got %h want %h", obs, exp_v); end
    init = 1'b0;
    tick();
    exp_v = pk(2, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL error_recover: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_drain_wrap();
    push = 1'b1; pop = 1'b0;
    repeat (7) tick();
    for (int i = 0; i < 7; i++) begin
      push = 1'b0; pop = 1'b1;
      #1;
      total++;
      if ({strb, rd_ptr} !== {2'b01, 3'(i)}) begin
        bad++; $display("FAIL drain_strobe: got %b/%0d want 01/%0d", strb, rd_ptr, i);
      end
      tick();
      exp_v = pk(((6 - i) > 0) ? 3 : 2, 6 - i, 7, i + 1, 0, (6 - i) == 0, (6 - i) >= 5,
                 (6 - i) <= 1, 0, 1);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL drain_status: got %h want %h", obs, exp_v); end
    end
    pop = 1'b0;
    tick();
    exp_v = pk(2, 0, 7, 7, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL drain_valid_drop: got %h want %h", obs, exp_v); end
    for (int k = 0; k < 10; k++) begin
      push = 1'b1; pop = 1'b0;
      tick();
      exp_v = pk(3, 1, (8 + k) % 8, (7 + k) % 8, 0, 0, 0, 1, 0, 0);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL wrap_push: got %h want %h", obs, exp_v); end
      push = 1'b0; pop = 1'b1;
      tick();
      exp_v = pk(2, 0, (8 + k) % 8, (8 + k) % 8, 0, 1, 0, 1, 0, 1);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL wrap_pop: got %h want %h", obs, exp_v); end
    end
    pop = 1'b0;
    tick();
  endtask

  task automatic test_simul();
    push = 1'b1; pop = 1'b0;
    repeat (7) tick();
    exp_v = pk(3, 7, 0, 1, 1, 0, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL simul_full: got %h want %h", obs, exp_v); end
    pop = 1'b1;
    #1;
    total++;
    if (strb !== 2'b11) begin bad++; $display("FAIL simul_full_strobe: got %b want 11", strb); end
    tick();
    exp_v = pk(3, 7, 1, 2, 1, 0, 1, 0, 0, 1);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL simul_full_status: got %h want %h", obs, exp_v); end
    push = 1'b0;
    repeat (7) tick();
    pop = 1'b0;
    tick();
    exp_v = pk(2, 0, 1, 1, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL simul_drained: got %h want %h", obs, exp_v); end
    push = 1'b1; pop = 1'b1;
    #1;
    total++;
    if (strb !== 2'b10) begin bad++; $display("FAIL simul_empty_strobe: got %b want 10", strb); end
    tick();
    total++;
    if ({state, error} !== {3'd4, 1'b1}) begin
      bad++; $display("FAIL simul_underflow: got %0d/%b want 4/1", state, error);
    end
    push = 1'b0; pop = 1'b0; init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    exp_v = pk(2, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL simul_recover: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_init_midway();
    push = 1'b1; pop = 1'b0;
    repeat (4) tick();
    exp_v = pk(3, 4, 4, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL init_pre: got %h want %h", obs, exp_v); end
    push = 1'b0; init = 1'b1; th_afull = 3'd3; th_aempty = 3'd4;
    tick();
    exp_v = pk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL init_enter: got %h want %h", obs, exp_v); end
    init = 1'b0;
    tick();
    push = 1'b1;
    repeat (3) tick();
    exp_v = pk(3, 3, 3, 0, 0, 0, 1, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL init_new_th: got %h want %h", obs, exp_v); end
    repeat (2) tick();
    exp_v = pk(3, 5, 5, 0, 0, 0, 1, 0, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL init_new_th2: got %h want %h", obs, exp_v); end
    reset = 1'b1;
    #1;
    total++;
    if (strb !== 2'b00) begin bad++; $display("FAIL midreset_strobe: got %b want 00", strb); end
    tick();
    exp_v = pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midreset_state: got %h want %h", obs, exp_v); end
    reset = 1'b0; push = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    int q[$];
    int st, wr, rd, af, ae, n;
    bit er, v, op, ewr, erd, ovf, udf;
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0;
    tick();
    st = 0; wr = 0; rd = 0; af = 0; ae = 0; er = 1'b0; v = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ((cyc / 100) % 2 == 0) begin
        push = ($urandom_range(0, 99) < 75); pop = ($urandom_range(0, 99) < 30);
      end else begin
        push = ($urandom_range(0, 99) < 30); pop = ($urandom_range(0, 99) < 75);
      end
      if (q.size() == 0 && $urandom_range(0, 9) != 0) pop = 1'b0;
      init = (st == 4) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      th_afull  = 3'($urandom_range(0, 7));
      th_aempty = 3'($urandom_range(0, 7));
      op  = (st == 2 || st == 3) && !init && !reset;
      erd = op && pop && (q.size() > 0);
      ewr = op && push && ((q.size() < 7) || erd);
      #1;
      total++;
      if (strb !== {ewr, erd}) begin
        bad++; $display("FAIL rand_strobe: cyc %0d got %b want %b", cyc, strb, {ewr, erd});
      end
      if (erd) begin
        total++;
        if (rd_ptr !== 3'(q[0])) begin
          bad++; $display("FAIL rand_rd_slot: cyc %0d got %0d want %0d", cyc, rd_ptr, q[0]);
        end
      end
      if (reset) begin
        st = 0; wr = 0; rd = 0; af = 0; ae = 0; er = 1'b0; q.delete();
      end else begin
        case (st)
          0: st = 1;
          1: begin
            af = th_afull; ae = th_aempty; q.delete(); wr = 0; rd = 0; er = 1'b0;
            st = init ? 1 : 2;
          end
          2, 3: begin
            if (init) begin
              st = 1; q.delete(); wr = 0; rd = 0; er = 1'b0;
            end else begin
              ovf = push && (q.size() == 7) && !pop;
              udf = pop && (q.size() == 0);
              if (erd) begin void'(q.pop_front()); rd = (rd + 1) % 8; end
              if (ewr) begin q.push_back(wr); wr = (wr + 1) % 8; end
              if (ovf || udf) begin st = 4; er = 1'b1; end
              else st = (q.size() > 0) ? 3 : 2;
            end
          end
          default: begin
            if (init) begin st = 1; q.delete(); wr = 0; rd = 0; er = 1'b0; end
          end
        endcase
      end
      v = erd;
      tick();
      n = q.size();
      if (st == 0) exp_v = pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      else         exp_v = pk(st, n, wr, rd, n == 7, n == 0, n >= af, n <= ae, er, v);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL rand_status: cyc %0d got %h want %h", cyc, obs, exp_v);
      end
    end
    reset = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0;
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0; th_afull = '0; th_aempty = '0;
    test_reset();
    test_fill_overflow();
    test_drain_wrap();
    test_simul();
    test_init_midway();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
